// File: rtl/pck_injct_gen_pkg.sv
// Shared types for the packet-injector traffic generator: injector bus payload, FSM states, payload layout.
package pck_injct_gen_pkg;

  localparam int unsigned EAW      = 8;
  localparam int unsigned V        = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SIZE_W   = 8;
  localparam int unsigned CLASS_W  = 2;
  localparam int unsigned WEIGHT_W = 4;

  localparam int unsigned SEQ_LSB  = 0;
  localparam int unsigned SEQ_W    = 16;
  localparam int unsigned SIZE_LSB = 16;
  localparam int unsigned SRC_LSB  = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    GAP,
    DONE
  } gen_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [SIZE_W-1:0]   size;
    logic [EAW-1:0]      endp_addr;
    logic [CLASS_W-1:0]  class_num;
    logic [WEIGHT_W-1:0] init_weight;
    logic [V-1:0]        vc;
    logic                pck_wr;
    logic [V-1:0]        ready;
  } pck_injct_t;

  // Generated payload: sequence number, packet size and source address; unused bits zero.
  function automatic logic [DATA_W-1:0] build_payload(
    input logic [SEQ_W-1:0]  seq,
    input logic [SIZE_W-1:0] size,
    input logic [EAW-1:0]    src
  );
    logic [DATA_W-1:0] d;
    d = '0;
    d[SEQ_LSB  +: SEQ_W]  = seq;
    d[SIZE_LSB +: SIZE_W] = size;
    d[SRC_LSB  +: EAW]    = src;
    return d;
  endfunction

endpackage

// File: rtl/pck_injct_chk.sv
// Receive-side payload checker: counts deliveries whose embedded size/source disagree with the header.
module pck_injct_chk
  import pck_injct_gen_pkg::*;
#(
  parameter int unsigned CNTw = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pck_wr,
  input  logic [SIZE_W-1:0] pay_size,
  input  logic [SIZE_W-1:0] rsp_size,
  input  logic [EAW-1:0]    pay_src,
  input  logic [EAW-1:0]    rsp_src,
  output logic [CNTw-1:0]   err_cnt
);

  logic bad_c;

  assign bad_c = pck_wr && ((pay_size != rsp_size) || (pay_src != rsp_src));

  // Saturating error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (bad_c && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNTw'(1);
    end
  end

endmodule

// File: rtl/pck_injct_traffic_gen.sv
// Packet source/sink for one endpoint on a packet_injector port: programmed burst out, delivery count in.
// Optional payload checker enabled by defining PCK_INJ_GEN_CHK_EN.
module pck_injct_traffic_gen
  import pck_injct_gen_pkg::*;
#(
  parameter int unsigned NOC_ID     = 0,
  parameter int unsigned MIN_SIZE   = 3,
  parameter int unsigned MAX_SIZE   = 20,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNTw       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EAW-1:0]  current_e_addr,
  input  logic            start,
  input  logic [CNTw-1:0] pck_num,
  input  logic [EAW-1:0]  dest_e_addr,
  input  logic [V-1:0]    vc_sel,
  output pck_injct_t      inj_req,
  input  pck_injct_t      inj_rsp,
  output logic            busy,
  output logic            done,
  output logic [CNTw-1:0] sent_cnt,
  output logic [CNTw-1:0] recv_cnt,
  output logic [CNTw-1:0] err_cnt
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Only the NoC 0 field layout is provided by the package
  if ((NOC_ID != 0) || (MIN_SIZE < 1) || (MAX_SIZE < MIN_SIZE) || (MAX_SIZE >= (1 << SIZE_W)))
  begin : g_bad_cfg
    $error("pck_injct_traffic_gen: unsupported NOC_ID or size range");
  end

  gen_state_e        state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  pck_injct_t        req_d;
  logic              busy_d, done_d;

  logic [CNTw-1:0]   pck_num_q;
  logic [EAW-1:0]    dest_q;
  logic [V-1:0]      vc_q;
  logic [SIZE_W-1:0] size_q;

  logic              start_ok_c;
  logic              rdy_c;
  logic              last_c;
  logic              unused_rsp;

  assign start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign rdy_c      = |(inj_rsp.ready & vc_q);
  assign last_c     = (sent_cnt + CNTw'(1)) == pck_num_q;
  assign unused_rsp = ^{inj_rsp.data, inj_rsp.size, inj_rsp.endp_addr,
                        inj_rsp.class_num, inj_rsp.init_weight, inj_rsp.vc};

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    req_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (pck_num == '0) ? DONE : WAIT_RDY;
      end
      WAIT_RDY: begin
        if (rdy_c) state_d = ISSUE;
      end
      ISSUE: begin
        if (last_c) begin
          state_d = DONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = WAIT_RDY;
        end else begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if ((32'(gap_q) + 32'd1) >= GAP_CYCLES) state_d = WAIT_RDY;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // The request is registered, so it is built while entering ISSUE
    if (state_d == ISSUE) begin
      req_d.data        = build_payload(SEQ_W'(sent_cnt), size_q, current_e_addr);
      req_d.size        = size_q;
      req_d.endp_addr   = dest_q;
      req_d.class_num   = '0;
      req_d.init_weight = WEIGHT_W'(1);
      req_d.vc          = vc_q;
      req_d.pck_wr      = 1'b1;
    end
    busy_d = (state_d == WAIT_RDY) || (state_d == ISSUE) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      inj_req <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      inj_req <= req_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Burst configuration, sequence and size counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pck_num_q <= '0;
      dest_q    <= '0;
      vc_q      <= '0;
      sent_cnt  <= '0;
      size_q    <= SIZE_W'(MIN_SIZE);
    end else if (start_ok_c) begin
      pck_num_q <= pck_num;
      dest_q    <= dest_e_addr;
      vc_q      <= vc_sel;
      sent_cnt  <= '0;
      size_q    <= SIZE_W'(MIN_SIZE);
    end else if (state_q == ISSUE) begin
      sent_cnt  <= sent_cnt + CNTw'(1);
      size_q    <= (size_q == SIZE_W'(MAX_SIZE)) ? SIZE_W'(MIN_SIZE) : size_q + SIZE_W'(1);
    end
  end

  // Delivery counter runs regardless of burst state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recv_cnt <= '0;
    end else if (inj_rsp.pck_wr) begin
      recv_cnt <= recv_cnt + CNTw'(1);
    end
  end

`ifdef PCK_INJ_GEN_CHK_EN
  pck_injct_chk #(
    .CNTw (CNTw)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .pck_wr   (inj_rsp.pck_wr),
    .pay_size (inj_rsp.data[SIZE_LSB +: SIZE_W]),
    .rsp_size (inj_rsp.size),
    .pay_src  (inj_rsp.data[SRC_LSB +: EAW]),
    .rsp_src  (inj_rsp.endp_addr),
    .err_cnt  (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pck_injct_traffic_gen.sv
// Directed self-checking bench for pck_injct_traffic_gen (3-cycle loopback for the delivery side).
module tb_pck_injct_traffic_gen;
  import pck_injct_gen_pkg::*;

  localparam int unsigned CNTW   = 32;
  localparam int unsigned MIN_SZ = 3;
  localparam int unsigned MAX_SZ = 20;
  localparam logic [EAW-1:0] OWN_ADDR = 8'h3A;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [CNTW-1:0] pck_num;
  logic [EAW-1:0]  dest_e_addr;
  logic [V-1:0]    vc_sel;
  pck_injct_t      inj_req;
  pck_injct_t      inj_rsp;
  logic            busy, done;
  logic [CNTW-1:0] sent_cnt, recv_cnt, err_cnt;

  logic [V-1:0]      rdy;
  logic              loop_en;
  logic              man_wr;
  logic [SIZE_W-1:0] man_size;
  logic [DATA_W-1:0] man_data;
  pck_injct_t        pipe [3];

  int n_cmp = 0;
  int n_err = 0;
  int         q_cyc [$];
  pck_injct_t q_pkt [$];

  always #5 clk = ~clk;

  pck_injct_traffic_gen #(
    .NOC_ID(0), .MIN_SIZE(MIN_SZ), .MAX_SIZE(MAX_SZ), .GAP_CYCLES(1), .CNTw(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .current_e_addr(OWN_ADDR), .start(start), .pck_num(pck_num),
    .dest_e_addr(dest_e_addr), .vc_sel(vc_sel), .inj_req(inj_req), .inj_rsp(inj_rsp),
    .busy(busy), .done(done), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .err_cnt(err_cnt)
  );

  // Loopback: issued packets come back 3 cycles later as deliveries from OWN_ADDR
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= loop_en ? inj_req : '0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  always_comb begin
    inj_rsp       = '0;
    inj_rsp.ready = rdy;
    if (pipe[2].pck_wr) begin
      inj_rsp.pck_wr    = 1'b1;
      inj_rsp.size      = pipe[2].size;
      inj_rsp.data      = pipe[2].data;
      inj_rsp.endp_addr = OWN_ADDR;
    end else if (man_wr) begin
      inj_rsp.pck_wr    = 1'b1;
      inj_rsp.size      = man_size;
      inj_rsp.data      = man_data;
      inj_rsp.endp_addr = OWN_ADDR;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic start_burst(input int unsigned n, input logic [EAW-1:0] dest, input logic [V-1:0] vc);
    @(negedge clk);
    pck_num = CNTW'(n); dest_e_addr = dest; vc_sel = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record every pck_wr cycle until done; optionally pulse start (pck_num=7) at cycle poke_at
  task automatic collect(input int budget, input int poke_at);
    int cyc;
    cyc = 0;
    q_cyc.delete();
    q_pkt.delete();
    while (!done && cyc < budget) begin
      if (inj_req.pck_wr) begin
        q_cyc.push_back(cyc);
        q_pkt.push_back(inj_req);
      end
      if (cyc == poke_at) begin
        pck_num = CNTW'(7); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_val("done_within_budget", 64'(done), 64'd1);
  endtask

  task automatic verify_burst(input string t, input int n_exp, input int seq0,
                              input logic [EAW-1:0] dest, input logic [V-1:0] vc, input int spacing);
    logic [SIZE_W-1:0] sz;
    logic [DATA_W-1:0] d;
    check_val({t, "_count"}, 64'(q_pkt.size()), 64'(n_exp));
    for (int k = 0; k < q_pkt.size(); k++) begin
      sz = SIZE_W'(MIN_SZ + ((seq0 + k) % (MAX_SZ - MIN_SZ + 1)));
      d  = DATA_W'({OWN_ADDR, sz, 16'(seq0 + k)});
      check_val($sformatf("%s_size%0d", t, k), 64'(q_pkt[k].size), 64'(sz));
      check_val($sformatf("%s_data%0d", t, k), 64'(q_pkt[k].data), 64'(d));
      check_val($sformatf("%s_endp%0d", t, k), 64'(q_pkt[k].endp_addr), 64'(dest));
      check_val($sformatf("%s_vc%0d", t, k), 64'(q_pkt[k].vc), 64'(vc));
      check_val($sformatf("%s_cls%0d", t, k), 64'(q_pkt[k].class_num), 64'd0);
      check_val($sformatf("%s_wgt%0d", t, k), 64'(q_pkt[k].init_weight), 64'd1);
      if (spacing > 0 && k > 0)
        check_val($sformatf("%s_gap%0d", t, k), 64'(q_cyc[k] - q_cyc[k-1]), 64'(spacing));
    end
  endtask

  task automatic deliver(input logic [SIZE_W-1:0] hdr_size, input logic [SIZE_W-1:0] pay_size);
    @(negedge clk);
    man_wr = 1'b1; man_size = hdr_size; man_data = DATA_W'({OWN_ADDR, pay_size, 16'h0});
    @(negedge clk);
    man_wr = 1'b0;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen, stalled;
    reset = 1'b0; start = 1'b0; pck_num = '0; dest_e_addr = '0; vc_sel = '0;
    rdy = '1; loop_en = 1'b0; man_wr = 1'b0; man_size = '0; man_data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_req", 64'(inj_req), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_sent", 64'(sent_cnt), 64'd0);
    check_val("rst_recv", 64'(recv_cnt), 64'd0);
    check_val("rst_err", 64'(err_cnt), 64'd0);
    reset = 1'b1;

    // 1: ten packets, looped back; deliveries coincide with later issues
    loop_en = 1'b1;
    start_burst(10, 8'h00, 4'b0001);
    check_val("t1_busy", 64'(busy), 64'd1);
    collect(200, -1);
    verify_burst("t1", 10, 0, 8'h00, 4'b0001, 3);
    check_val("t1_sent", 64'(sent_cnt), 64'd10);
    check_val("t1_busy_end", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    loop_en = 1'b0;
    check_val("t1_recv", 64'(recv_cnt), 64'd10);
    check_val("t1_err", 64'(err_cnt), 64'd0);

    // 2: VC0 ready held low for 50 cycles after the second packet
    start_burst(6, 8'h15, 4'b0001);
    seen = 0;
    for (int c = 0; c < 50 && seen < 2; c++) begin
      @(negedge clk);
      if (inj_req.pck_wr) seen++;
    end
    check_val("t2_pre", 64'(seen), 64'd2);
    rdy = 4'b1110;
    stalled = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (inj_req.pck_wr) stalled++;
    end
    check_val("t2_stall_wr", 64'(stalled), 64'd0);
    check_val("t2_stall_busy", 64'(busy), 64'd1);
    rdy = '1;
    @(negedge clk);
    check_val("t2_resume", 64'(inj_req.pck_wr), 64'd1);
    collect(200, -1);
    verify_burst("t2", 4, 2, 8'h15, 4'b0001, 3);
    check_val("t2_sent", 64'(sent_cnt), 64'd6);

    // 3: size counter wraps from MAX_SIZE back to MIN_SIZE
    start_burst(20, 8'h07, 4'b0100);
    collect(400, -1);
    verify_burst("t3", 20, 0, 8'h07, 4'b0100, 3);
    check_val("t3_sent", 64'(sent_cnt), 64'd20);

    // 4: empty burst, then a start while busy is ignored
    start_burst(0, 8'h01, 4'b0001);
    check_val("t4_zero_done", 64'(done), 64'd1);
    check_val("t4_zero_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (inj_req.pck_wr) seen++;
    end
    check_val("t4_zero_wr", 64'(seen), 64'd0);
    check_val("t4_zero_sent", 64'(sent_cnt), 64'd0);
    start_burst(3, 8'h22, 4'b0010);
    collect(100, 2);
    verify_burst("t4", 3, 0, 8'h22, 4'b0010, 3);
    check_val("t4_sent", 64'(sent_cnt), 64'd3);

    // Deliveries while idle; the last one carries a corrupted size
    deliver(8'd5, 8'd5);
    deliver(8'd9, 8'd9);
    deliver(8'd12, 8'd12);
    deliver(8'd4, 8'd4);
    deliver(8'd5, 8'd6);
    repeat (2) @(negedge clk);
    check_val("rx_recv", 64'(recv_cnt), 64'd15);
`ifdef PCK_INJ_GEN_CHK_EN
    check_val("rx_err", 64'(err_cnt), 64'd1);
`else
    check_val("rx_err", 64'(err_cnt), 64'd0);
`endif

    // 6: asynchronous reset mid-burst, then a clean burst
    start_burst(10, 8'h09, 4'b1000);
    seen = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(negedge clk);
      if (inj_req.pck_wr) seen++;
    end
    #2 reset = 1'b0;
    #1;
    check_val("t6_req", 64'(inj_req), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);
    check_val("t6_done", 64'(done), 64'd0);
    check_val("t6_sent", 64'(sent_cnt), 64'd0);
    check_val("t6_recv", 64'(recv_cnt), 64'd0);
    check_val("t6_err", 64'(err_cnt), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_burst(2, 8'h0C, 4'b0001);
    collect(100, -1);
    verify_burst("t6", 2, 0, 8'h0C, 4'b0001, 3);
    check_val("t6_sent_end", 64'(sent_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
